// File: rtl/banco_reg_file_pkg.sv
// ---------------------------------------------------------------------------
// banco_reg_pkg
// Shared widths and types for the banco_reg_file register bank.
//   DATA_W : width of one register and of the write/read data paths
//   ADDR_W : width of every register address
//   DEPTH  : number of registers, always 2**ADDR_W
// Types:
//   data_t : one register word
//   addr_t : one register address
// Optional build macro used by the bank: BANCO_REG_FILE_BYPASS_EN
// ---------------------------------------------------------------------------
package banco_reg_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;

endpackage : banco_reg_pkg

// File: rtl/banco_reg_file_if.sv
// ---------------------------------------------------------------------------
// banco_reg_file_if
// Bus between the datapath control/decoder and the register bank.
//   AddrR1 : read address for port RX
//   AddrR2 : read address for port RY
//   AddrW  : write address
//   DataIn : write data
//   W_R    : write enable (1 = write on rising clk, 0 = read only)
//   RX     : contents of register[AddrR1]
//   RY     : contents of register[AddrR2]
// Modports:
//   master : the control side that drives addresses and write data
//   slave  : the register bank that answers with RX/RY
// ---------------------------------------------------------------------------
interface banco_reg_file_if;
  import banco_reg_pkg::*;

  addr_t AddrR1;
  addr_t AddrR2;
  addr_t AddrW;
  data_t DataIn;
  logic  W_R;
  data_t RX;
  data_t RY;

  modport master (
    output AddrR1,
    output AddrR2,
    output AddrW,
    output DataIn,
    output W_R,
    input  RX,
    input  RY
  );

  modport slave (
    input  AddrR1,
    input  AddrR2,
    input  AddrW,
    input  DataIn,
    input  W_R,
    output RX,
    output RY
  );

endinterface : banco_reg_file_if

// File: rtl/banco_reg_file_read_port.sv
// ---------------------------------------------------------------------------
// banco_reg_read_port
// One asynchronous read port of the register bank: a DEPTH:1 mux over the
// stored registers, optionally followed by a write-through forward.
// Ports:
//   regs    in  DEPTH x data_t  stored register contents
//   addr    in  addr_t          register to read
//   wr_en   in  1               qualified write enable (only with bypass)
//   wr_addr in  addr_t          write address (only with bypass)
//   wr_data in  data_t          write data (only with bypass)
//   dout    out data_t          selected value
// Build macro: BANCO_REG_FILE_BYPASS_EN
//   defined   : a pending write to the addressed register is forwarded
//   undefined : read-before-write, dout reflects stored contents only
// ---------------------------------------------------------------------------
module banco_reg_read_port
  import banco_reg_pkg::*;
(
  input  data_t regs [DEPTH],
  input  addr_t addr,
`ifdef BANCO_REG_FILE_BYPASS_EN
  input  logic  wr_en,
  input  addr_t wr_addr,
  input  data_t wr_data,
`endif
  output data_t dout
);

  always_comb begin
    dout = regs[addr];
`ifdef BANCO_REG_FILE_BYPASS_EN
    // wr_en already excludes reset, so a held reset never forwards data
    if (wr_en && (wr_addr == addr)) begin
      dout = wr_data;
    end
`endif
  end

endmodule : banco_reg_read_port

// File: rtl/banco_reg_file.sv
// ---------------------------------------------------------------------------
// banco_reg_file
// General-purpose register bank: DEPTH registers of DATA_W bits, one
// synchronous write port and two independent asynchronous read ports.
// Ports:
//   clk   in  1      system clock, state updates on the rising edge
//   reset in  1      asynchronous active-high reset, clears every register
//   bus   slave      banco_reg_file_if (AddrR1/AddrR2/AddrW/DataIn/W_R in,
//                    RX/RY out)
// Build macro: BANCO_REG_FILE_BYPASS_EN
//   defined   : write-through forwarding on RX/RY when the read address
//               matches a pending write
//   undefined : read-before-write; RX/RY show stored contents only
// Register 0 is an ordinary writable register. Reset release must be clean
// relative to clk; there is no internal synchronizer.
// ---------------------------------------------------------------------------
module banco_reg_file
  import banco_reg_pkg::*;
(
  input logic               clk,
  input logic               reset,
  banco_reg_file_if.slave   bus
);

  data_t regs [DEPTH];

  // Storage and write decode. Reset wins over a write on the same edge, and
  // because it is asynchronous the array is zero while reset is held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (bus.W_R) begin
      regs[bus.AddrW] <= bus.DataIn;
    end
  end

`ifdef BANCO_REG_FILE_BYPASS_EN
  logic wr_active;

  // Forwarding must never show DataIn while reset holds the array at zero
  assign wr_active = bus.W_R & ~reset;
`endif

  banco_reg_read_port u_read_rx (
    .regs    (regs),
    .addr    (bus.AddrR1),
`ifdef BANCO_REG_FILE_BYPASS_EN
    .wr_en   (wr_active),
    .wr_addr (bus.AddrW),
    .wr_data (bus.DataIn),
`endif
    .dout    (bus.RX)
  );

  banco_reg_read_port u_read_ry (
    .regs    (regs),
    .addr    (bus.AddrR2),
`ifdef BANCO_REG_FILE_BYPASS_EN
    .wr_en   (wr_active),
    .wr_addr (bus.AddrW),
    .wr_data (bus.DataIn),
`endif
    .dout    (bus.RY)
  );

endmodule : banco_reg_file

// File: tb/tb_banco_reg_file.sv
// ---------------------------------------------------------------------------
// tb_banco_reg_file
// Self-checking bench for banco_reg_file. Stimulus pushes the expected RX/RY
// pair into a queue and raises a sample event; a separate monitor pops and
// compares against the live outputs.
// Build macro honoured: BANCO_REG_FILE_BYPASS_EN (changes the pre-edge
// collision expectation only).
// ---------------------------------------------------------------------------
module tb_banco_reg_file;
  import banco_reg_pkg::*;

  typedef struct {
    string name;
    data_t rx;
    data_t ry;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  exp_t exp_q[$];
  int   check_count = 0;
  int   pass_count  = 0;
  event sample_ev;

  banco_reg_file_if bus ();

  banco_reg_file dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Drive every bus input in one go
  task automatic apply_stimulus(input addr_t r1, input addr_t r2,
                                input addr_t aw, input data_t din,
                                input logic wr);
    bus.AddrR1 = r1;
    bus.AddrR2 = r2;
    bus.AddrW  = aw;
    bus.DataIn = din;
    bus.W_R    = wr;
  endtask

  // Queue the expectation and ask the monitor to sample now
  task automatic check_output(input string name, input data_t rx,
                              input data_t ry);
    exp_t e;
    e.name = name;
    e.rx   = rx;
    e.ry   = ry;
    exp_q.push_back(e);
    -> sample_ev;
    #1;
  endtask

  // Monitor: compares the live outputs against the oldest expectation
  initial begin : monitor
    exp_t e;
    forever begin
      @(sample_ev);
      check_count++;
      if (exp_q.size() == 0) begin
        $display("[TB] FAIL monitor: sample with no expectation queued, RX=%h RY=%h",
                 bus.RX, bus.RY);
      end else begin
        e = exp_q.pop_front();
        if (bus.RX === e.rx && bus.RY === e.ry) begin
          pass_count++;
        end else begin
          $display("[TB] FAIL %s: got RX=%h RY=%h, expected RX=%h RY=%h",
                   e.name, bus.RX, bus.RY, e.rx, e.ry);
        end
      end
    end
  end

  initial begin : stimulus
    data_t fill_vals [8] = '{8'hFD, 8'hFE, 8'hAD, 8'hFF, 8'hFF, 8'h07, 8'h06, 8'h0A};
    data_t fill_rx   [8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h07, 8'h07, 8'h07};
    data_t fill_ry   [8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h06, 8'h06};
    data_t final_vals[8] = '{8'h0A, 8'hFE, 8'hAD, 8'hFF, 8'hFF, 8'h07, 8'h06, 8'h0A};
    data_t coll_pre;
    addr_t aw;

`ifdef BANCO_REG_FILE_BYPASS_EN
    coll_pre = 8'h3C;
`else
    coll_pre = 8'hAD;
`endif

    // Reset held with a write request pending: nothing may be stored
    reset = 1'b1;
    apply_stimulus(3'd5, 3'd6, 3'd0, 8'hFD, 1'b1);
    @(posedge clk);
    #1;
    check_output("reset_hold", 8'h00, 8'h00);
    apply_stimulus(3'd0, 3'd0, 3'd0, 8'hFD, 1'b1);
    #1;
    check_output("reset_r0", 8'h00, 8'h00);
    @(negedge clk);
    reset = 1'b0;

    // Sequential fill r0..r7, watching RX=r5 and RY=r6
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      apply_stimulus(3'd5, 3'd6, addr_t'(i), fill_vals[i], 1'b1);
      @(posedge clk);
      #1;
      check_output($sformatf("fill_w%0d", i), fill_rx[i], fill_ry[i]);
    end

    // Address wrap: 7 + 1 lands on r0
    aw = 3'd7;
    aw = aw + 3'd1;
    @(negedge clk);
    apply_stimulus(3'd5, 3'd6, aw, 8'h0A, 1'b1);
    @(posedge clk);
    #1;
    check_output("wrap_write", 8'h07, 8'h06);
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(addr_t'(i), addr_t'(7 - i), 3'd0, 8'h00, 1'b0);
      #1;
      check_output($sformatf("readback_%0d", i), final_vals[i], final_vals[7 - i]);
    end

    // Write disabled over several edges
    @(negedge clk);
    apply_stimulus(3'd3, 3'd3, 3'd3, 8'h55, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_output("wr_disable", 8'hFF, 8'hFF);

    // Dual read of the register being written
    @(negedge clk);
    apply_stimulus(3'd2, 3'd2, 3'd2, 8'h3C, 1'b1);
    #1;
    check_output("collision_pre", coll_pre, coll_pre);
    @(posedge clk);
    #1;
    check_output("collision_post", 8'h3C, 8'h3C);

    // Asynchronous reset between edges
    @(negedge clk);
    apply_stimulus(3'd5, 3'd6, 3'd0, 8'h00, 1'b0);
    #1;
    check_output("pre_reset", 8'h07, 8'h06);
    #1;
    reset = 1'b1;
    #1;
    check_output("async_reset", 8'h00, 8'h00);
    for (int i = 0; i < 8; i += 2) begin
      apply_stimulus(addr_t'(i), addr_t'(i + 1), 3'd0, 8'h00, 1'b0);
      #1;
      check_output($sformatf("reset_read_%0d", i), 8'h00, 8'h00);
    end

    // Reset overrides a write on the same edge
    apply_stimulus(3'd1, 3'd1, 3'd1, 8'hAA, 1'b1);
    @(posedge clk);
    #1;
    check_output("reset_over_write", 8'h00, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    apply_stimulus(3'd1, 3'd1, 3'd1, 8'hAA, 1'b0);
    #1;
    check_output("post_reset", 8'h00, 8'h00);

    // Drain the scoreboard with a bounded wait
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) begin
      #1;
    end
    if (exp_q.size() != 0) begin
      check_count++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule : tb_banco_reg_file
